ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of 24-bit words expected per frame.
REQ-002 Parameter T_THRESH, default 10, high-pulse width in clk cycles at or above which a bit decodes as 1.
REQ-003 Parameter T_MAX_HIGH, default 20, high-pulse width in cycles above which the pulse is a protocol error.
REQ-004 Parameter T_RESET, default 800, continuous low cycles that terminate a frame (50us at 16MHz).
REQ-005 clk  input  1  system clock, 16MHz nominal.
REQ-006 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-007 din  input  1  asynchronous WS2812 serial line.
REQ-008 rgb_data  output  24  last decoded word, first received bit in bit 23.
REQ-009 led_num  output  8  index of the word in rgb_data within its frame, 0-based.
REQ-010 valid  output  1  one-cycle pulse: rgb_data/led_num updated this cycle.
REQ-011 frame_done  output  1  one-cycle pulse at end of frame.
REQ-012 word_count  output  8  words received in the frame just ended; updated with frame_done.
REQ-013 error  output  1  one-cycle pulse on any protocol error.

Function
REQ-014 din SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized signal ds, so decode latency from pin is 2 cycles plus the stated latencies.
REQ-015 States: SYNC, IDLE, HIGH, LOW.
REQ-016 SYNC: count consecutive ds=0 cycles; any ds=1 clears the count; count reaching T_RESET -> IDLE, with no frame_done.
REQ-017 IDLE: ds=1 -> HIGH with high counter = 1; ds=0 stays.
REQ-018 HIGH: high counter increments per ds=1 cycle, saturating at 255; exceeding T_MAX_HIGH -> error pulse, discard partial word, led index cleared, -> SYNC.
REQ-019 HIGH, ds=0 (falling edge): decoded bit = (high counter >= T_THRESH); shift into 24-bit shift register MSB-first; bit counter increments; low counter = 1; -> LOW.
REQ-020 When the 24th bit of a word is shifted, the cycle after the falling edge SHALL assert valid with rgb_data = completed word and led_num = current led index; led index then increments, saturating at 255; bit counter returns to 0.
REQ-021 Words beyond NUM_LEDS SHALL still be output with valid; word_count reflects all words, saturating at 255.
REQ-022 LOW: ds=1 -> HIGH (new bit, high counter = 1); low counter increments per ds=0 cycle, saturating.
REQ-023 Low counter reaching T_RESET: frame_done pulse, word_count = led index, led index cleared -> IDLE; if bit counter != 0 at that point, error also pulses and the partial word is discarded (no valid).
REQ-024 frame_done with zero words SHALL never occur: IDLE does not time out.
REQ-025 valid and frame_done SHALL never assert in the same cycle (guaranteed by T_RESET > 1).
REQ-026 rgb_data, led_num, word_count hold their values between updates.
REQ-027 Counters SHALL be wide enough for T_RESET without wrap (10 bits minimum at default).

Reset
REQ-028 On reset: state SYNC, all counters, shift register, led index cleared; rgb_data=0, led_num=0, word_count=0, valid=0, frame_done=0, error=0; synchronizer flops cleared.
REQ-029 Reset asserted mid-frame SHALL discard all in-progress data; decoding resumes only after a full T_RESET low gap.

Verification
REQ-030 Reset, din low 800 cycles, then one word 0xA5F00F (1 = 13 high/7 low, 0 = 7 high/13 low), then low 800 -> valid once with rgb_data=0xA5F00F, led_num=0; frame_done with word_count=1.
REQ-031 After sync, 8 words 0x000001..0x000008 then gap -> 8 valid pulses, led_num 0..7 in order, word_count=8.
REQ-032 After sync, 12 bits then low 800 -> error and frame_done pulse, word_count=0, no valid.
REQ-033 After sync, a 25-cycle high pulse -> error; following word without 800-cycle gap produces no valid; after gap, next word decodes normally.
REQ-034 din toggling from reset release without any 800-cycle low -> no valid, no frame_done.
REQ-035 Reset pulsed during bit 10 of word 1 -> all outputs 0; subsequent gap + word decodes with led_num=0.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx -- WS2812 serial line receiver.
//
// Decodes the single-wire WS2812 protocol. The width of each high pulse
// decides the bit value, and a long low gap ends the frame. Bits are
// assembled MSB-first into 24-bit words, and each word is presented with
// its index within the frame.
//
// Ports:
//   clk        in   system clock (16 MHz nominal)
//   reset      in   synchronous, active-high reset
//   din        in   asynchronous WS2812 serial line
//   rgb_data   out  last decoded word; the first received bit is in bit 23
//   led_num    out  0-based index of rgb_data within its frame
//   valid      out  one-cycle pulse when rgb_data/led_num are updated
//   frame_done out  one-cycle pulse at the end of a frame
//   word_count out  number of words in the frame that just ended
//   error      out  one-cycle pulse on any protocol error
module ws2812_rx #(
  parameter int NUM_LEDS   = 8,
  parameter int T_THRESH   = 10,
  parameter int T_MAX_HIGH = 20,
  parameter int T_RESET    = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic [7:0]  word_count,
  output logic        error
);

  // The low counter must reach T_RESET without wrapping. It is never
  // narrower than 10 bits.
  localparam int CW_RAW = $clog2(T_RESET + 1);
  localparam int CW     = (CW_RAW < 10) ? 10 : CW_RAW;
  localparam logic [CW-1:0] LOW_LAST = CW'(T_RESET - 1);
  localparam logic [CW-1:0] LOW_MAX  = {CW{1'b1}};

  // Frame termination and the valid/frame_done separation both rely on
  // T_RESET being larger than one cycle.
  if (T_RESET < 2 || NUM_LEDS < 1) begin : g_param_check
    $error("ws2812_rx: T_RESET must be >= 2 and NUM_LEDS >= 1");
  end

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t        state, state_n;
  logic          sync1, ds;
  logic [7:0]    high_cnt, high_n;
  logic [CW-1:0] low_cnt, low_n;
  logic [22:0]   shift, shift_n;
  logic [4:0]    bit_cnt, bit_n;
  logic [7:0]    led_idx, led_n;
  logic [23:0]   rgb_n;
  logic [7:0]    led_num_n, word_count_n;
  logic          valid_n, frame_done_n, error_n;
  logic [7:0]    high_inc;
  logic [CW-1:0] low_inc;
  logic          bit_val;

  // Two-flop synchronizer. Everything downstream sees only ds.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      ds    <= 1'b0;
    end else begin
      sync1 <= din;
      ds    <= sync1;
    end
  end

  assign high_inc = (high_cnt == 8'hFF) ? high_cnt : high_cnt + 8'd1;
  assign low_inc  = (low_cnt == LOW_MAX) ? low_cnt : low_cnt + 1'b1;
  assign bit_val  = (int'(high_cnt) >= T_THRESH);

  // State and datapath registers. All outputs are registered, so a
  // word completed on a falling edge shows up as valid one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      high_cnt   <= '0;
      low_cnt    <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      led_idx    <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      word_count <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      high_cnt   <= high_n;
      low_cnt    <= low_n;
      shift      <= shift_n;
      bit_cnt    <= bit_n;
      led_idx    <= led_n;
      rgb_data   <= rgb_n;
      led_num    <= led_num_n;
      word_count <= word_count_n;
      valid      <= valid_n;
      frame_done <= frame_done_n;
      error      <= error_n;
    end
  end

  // Next-state and datapath logic. Everything holds by default, and the
  // pulse outputs default low.
  always_comb begin
    state_n      = state;
    high_n       = high_cnt;
    low_n        = low_cnt;
    shift_n      = shift;
    bit_n        = bit_cnt;
    led_n        = led_idx;
    rgb_n        = rgb_data;
    led_num_n    = led_num;
    word_count_n = word_count;
    valid_n      = 1'b0;
    frame_done_n = 1'b0;
    error_n      = 1'b0;

    case (state)
      // Wait for a full reset-length low gap before trusting the line.
      // No frame_done is produced here.
      SYNC: begin
        if (ds) begin
          low_n = '0;
        end else if (low_cnt >= LOW_LAST) begin
          low_n   = '0;
          state_n = IDLE;
        end else begin
          low_n = low_inc;
        end
      end

      // IDLE deliberately never times out, so an empty frame can
      // never report frame_done.
      IDLE: begin
        if (ds) begin
          high_n  = 8'd1;
          state_n = HIGH;
        end
      end

      HIGH: begin
        if (ds) begin
          high_n = high_inc;
          if (int'(high_inc) > T_MAX_HIGH) begin
            error_n = 1'b1;
            shift_n = '0;
            bit_n   = '0;
            led_n   = '0;
            low_n   = '0;
            state_n = SYNC;
          end
        end else begin
          // Falling edge: the width of the pulse just finished decides
          // the bit value.
          low_n   = {{(CW-1){1'b0}}, 1'b1};
          state_n = LOW;
          if (bit_cnt == 5'd23) begin
            rgb_n     = {shift, bit_val};
            led_num_n = led_idx;
            valid_n   = 1'b1;
            led_n     = (led_idx == 8'hFF) ? led_idx : led_idx + 8'd1;
            bit_n     = '0;
            shift_n   = '0;
          end else begin
            shift_n = {shift[21:0], bit_val};
            bit_n   = bit_cnt + 5'd1;
          end
        end
      end

      LOW: begin
        if (ds) begin
          high_n  = 8'd1;
          state_n = HIGH;
        end else if (low_cnt >= LOW_LAST) begin
          // Frame end. A half-received word is dropped and flagged.
          frame_done_n = 1'b1;
          word_count_n = led_idx;
          error_n      = (bit_cnt != 5'd0);
          led_n        = '0;
          bit_n        = '0;
          shift_n      = '0;
          low_n        = '0;
          state_n      = IDLE;
        end else begin
          low_n = low_inc;
        end
      end

      default: state_n = SYNC;
    endcase
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx -- directed self-checking bench for ws2812_rx.
//
// A 1 bit is 13 cycles high and 7 low; a 0 bit is 7 high and 13 low.
// A monitor logs every valid/frame_done/error pulse on the falling clock
// edge. Each scenario compares the growth of those logs against values
// worked out by hand.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic [7:0]  word_count;
  logic        error;

  int checkCount = 0;
  int errorCount = 0;

  int          valid_cnt = 0;
  int          fd_cnt = 0;
  int          err_cnt = 0;
  int          overlap_cnt = 0;
  logic [7:0]  last_wc = '0;
  logic [23:0] log_word [0:255];
  logic [7:0]  log_led  [0:255];

  int base_v, base_f, base_e;

  ws2812_rx #(
    .NUM_LEDS(8), .T_THRESH(10), .T_MAX_HIGH(20), .T_RESET(800)
  ) dut (
    .clk(clk), .reset(reset), .din(din),
    .rgb_data(rgb_data), .led_num(led_num), .valid(valid),
    .frame_done(frame_done), .word_count(word_count), .error(error)
  );

  always #5 clk = ~clk;

  // Log every output pulse, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      if (valid_cnt < 256) begin
        log_word[valid_cnt] = rgb_data;
        log_led[valid_cnt]  = led_num;
      end
      valid_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      last_wc = word_count;
    end
    if (error) err_cnt++;
    if (valid && frame_done) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdLevel(input logic level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      din = level;
    end
  endtask

  task automatic sendBit(input logic b);
    holdLevel(1'b1, b ? 13 : 7);
    holdLevel(1'b0, b ? 7 : 13);
  endtask

  task automatic sendBits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) sendBit(w[23 - i]);
  endtask

  task automatic markBase();
    base_v = valid_cnt;
    base_f = fd_cnt;
    base_e = err_cnt;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_rgb", 32'(rgb_data), 32'h0);
    checkOutput("rst_led", 32'(led_num), 32'h0);
    checkOutput("rst_wc", 32'(word_count), 32'h0);
    checkOutput("rst_valid", 32'(valid), 32'h0);
    checkOutput("rst_fd", 32'(frame_done), 32'h0);
    checkOutput("rst_err", 32'(error), 32'h0);
    reset = 1'b0;

    // Single word after the initial sync gap.
    markBase();
    holdLevel(1'b0, 820);
    sendBits(24'hA5F00F, 24);
    holdLevel(1'b0, 820);
    checkOutput("w1_valid_n", 32'(valid_cnt - base_v), 32'd1);
    checkOutput("w1_data", 32'(log_word[base_v]), 32'h00A5F00F);
    checkOutput("w1_led", 32'(log_led[base_v]), 32'd0);
    checkOutput("w1_fd_n", 32'(fd_cnt - base_f), 32'd1);
    checkOutput("w1_wc", 32'(last_wc), 32'd1);
    checkOutput("w1_err_n", 32'(err_cnt - base_e), 32'd0);

    // Eight words in one frame.
    markBase();
    for (int i = 1; i <= 8; i++) sendBits(24'(i), 24);
    holdLevel(1'b0, 820);
    checkOutput("w8_valid_n", 32'(valid_cnt - base_v), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("w8_data%0d", i), 32'(log_word[base_v + i]), 32'(i + 1));
      checkOutput($sformatf("w8_led%0d", i), 32'(log_led[base_v + i]), 32'(i));
    end
    checkOutput("w8_fd_n", 32'(fd_cnt - base_f), 32'd1);
    checkOutput("w8_wc", 32'(last_wc), 32'd8);

    // Partial word followed by a frame gap.
    markBase();
    sendBits(24'hFFF000, 12);
    holdLevel(1'b0, 820);
    checkOutput("part_err_n", 32'(err_cnt - base_e), 32'd1);
    checkOutput("part_fd_n", 32'(fd_cnt - base_f), 32'd1);
    checkOutput("part_wc", 32'(last_wc), 32'd0);
    checkOutput("part_valid_n", 32'(valid_cnt - base_v), 32'd0);

    // Over-long high pulse, then a word with no resync gap.
    markBase();
    holdLevel(1'b1, 25);
    holdLevel(1'b0, 7);
    sendBits(24'h0F0F0F, 24);
    holdLevel(1'b0, 10);
    checkOutput("long_err_n", 32'(err_cnt - base_e), 32'd1);
    checkOutput("long_valid_n", 32'(valid_cnt - base_v), 32'd0);
    holdLevel(1'b0, 820);
    checkOutput("long_fd_n", 32'(fd_cnt - base_f), 32'd0);
    markBase();
    sendBits(24'h123456, 24);
    holdLevel(1'b0, 820);
    checkOutput("resync_valid_n", 32'(valid_cnt - base_v), 32'd1);
    checkOutput("resync_data", 32'(log_word[base_v]), 32'h00123456);
    checkOutput("resync_led", 32'(log_led[base_v]), 32'd0);
    checkOutput("resync_fd_n", 32'(fd_cnt - base_f), 32'd1);

    // Toggling right after reset with no long low gap.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    markBase();
    sendBits(24'hDEADBE, 24);
    sendBits(24'h00FF00, 24);
    checkOutput("nosync_valid_n", 32'(valid_cnt - base_v), 32'd0);
    checkOutput("nosync_fd_n", 32'(fd_cnt - base_f), 32'd0);

    // Reset pulsed during bit 10 of the first word.
    holdLevel(1'b0, 820);
    sendBits(24'hAAAAAA, 9);
    holdLevel(1'b1, 5);
    @(negedge clk);
    reset = 1'b1;
    din   = 1'b0;
    @(negedge clk);
    checkOutput("mid_rgb", 32'(rgb_data), 32'h0);
    checkOutput("mid_led", 32'(led_num), 32'h0);
    checkOutput("mid_wc", 32'(word_count), 32'h0);
    checkOutput("mid_valid", 32'(valid), 32'h0);
    reset = 1'b0;
    markBase();
    holdLevel(1'b0, 820);
    sendBits(24'hC0FFEE, 24);
    holdLevel(1'b0, 820);
    checkOutput("mid_valid_n", 32'(valid_cnt - base_v), 32'd1);
    checkOutput("mid_data", 32'(log_word[base_v]), 32'h00C0FFEE);
    checkOutput("mid_led0", 32'(log_led[base_v]), 32'd0);
    checkOutput("mid_wc1", 32'(last_wc), 32'd1);

    checkOutput("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
